// File: rtl/ahb_slave_pkg.sv
// Shared types and default sizes for the AHB-Lite memory slave.
// Build option AHB_SLAVE_MEM_CLEAR_EN is consumed by ahb_slave_mem_array.
package ahb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 32;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored by the slave.
  function automatic logic is_active(input htrans_e t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-addressed RAM with synchronous write and registered read.
// With AHB_SLAVE_MEM_CLEAR_EN defined, every reset cycle zeroes all words.
module ahb_slave_mem_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef AHB_SLAVE_MEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  // Contents survive reset; only the write strobe is suppressed while in reset.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  // Read samples the pre-write contents when it coincides with a write.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// Zero-wait-state AHB-Lite memory slave: address/data-phase pipeline around a word RAM.
// Build option AHB_SLAVE_MEM_CLEAR_EN (see ahb_slave_mem_array) clears memory on reset.
module ahb_slave_mem
  import ahb_slave_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              hclk,
  input  logic              hresetn,
  output logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata
);

  localparam int memDepth = MEM_DEPTH;

  logic              hready_reg;
  logic              wr_pend_reg, wr_pend_next;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              rd_valid_reg, rd_valid_next;
  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] ram_rdata;

  // Only depths smaller than the address space need an explicit bound check.
  generate
    if (memDepth < (1 << ADDR_W)) begin : g_bounded
      assign in_range = (haddr < ADDR_W'(memDepth));
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign accept = hready_reg && is_active(htrans_e'(htrans));

  always_comb begin
    wr_pend_next  = 1'b0;
    rd_valid_next = 1'b0;
    if (accept && in_range) begin
      wr_pend_next  = hwrite;
      rd_valid_next = !hwrite;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hready_reg   <= 1'b0;
      wr_pend_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      hready_reg   <= 1'b1;
      wr_pend_reg  <= wr_pend_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  always_ff @(posedge hclk) begin
    if (accept) begin
      wr_addr_reg <= haddr;
    end
  end

  // Write data arrives in the data phase, so it commits one edge after its address.
  ahb_slave_mem_array #(
    .DEPTH (memDepth),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (hclk),
    .rst_n(hresetn),
    .we   (wr_pend_reg),
    .waddr(wr_addr_reg),
    .wdata(hwdata),
    .re   (rd_valid_next),
    .raddr(haddr),
    .rdata(ram_rdata)
  );

  assign hready = hready_reg;
  assign hrdata = rd_valid_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: directed cases plus randomized traffic against an array model.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hready;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [7:0]  haddr = 8'h00;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;

  int checks = 0;
  int fails  = 0;
  logic [31:0] model_mem [256];

  always #5 hclk = ~hclk;

  ahb_slave_mem dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .hready (hready),
    .htrans (htrans),
    .hwrite (hwrite),
    .haddr  (haddr),
    .hwdata (hwdata),
    .hrdata (hrdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of bus signals, let the edge happen, return at the following negedge.
  task automatic bus(input logic [1:0] t, input logic w, input logic [7:0] a, input logic [31:0] d);
    htrans = t;
    hwrite = w;
    haddr  = a;
    hwdata = d;
    @(posedge hclk);
    @(negedge hclk);
  endtask

  initial begin
    logic        prev_wr;
    logic [7:0]  prev_addr;
    logic [1:0]  t;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          cycles;

    // Reset for five edges, then release.
    hresetn = 1'b0;
    repeat (5) @(negedge hclk);
    hresetn = 1'b1;
    check_eq("rst_hready", 32'(hready), 32'h0);
    check_eq("rst_hrdata", hrdata, 32'h0);
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("hready_up", 32'(hready), 32'h1);
    $display("reset release: hready=%0d hrdata=%h", hready, hrdata);

    // Single write.
    bus(2'b10, 1'b1, 8'h0d, 32'h0);
    check_eq("wr_hrdata_ap", hrdata, 32'h0);
    bus(2'b00, 1'b0, 8'h00, 32'h5a5a5a5a);
    check_eq("wr_hrdata_dp", hrdata, 32'h0);
    check_eq("wr_mem_0d", dut.u_array.mem[8'h0d], 32'h5a5a5a5a);
    $display("write 0x0d <- 5a5a5a5a: mem=%h", dut.u_array.mem[8'h0d]);

    // Single read of a preloaded word.
    dut.u_array.mem[8'h1d] = 32'h5a5a5a5a;
    bus(2'b10, 1'b0, 8'h1d, 32'h0);
    check_eq("rd_1d", hrdata, 32'h5a5a5a5a);
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("rd_1d_clear", hrdata, 32'h0);
    $display("read 0x1d -> 5a5a5a5a then 0");

    // Back-to-back reads.
    dut.u_array.mem[8'h10] = 32'hffffff00;
    dut.u_array.mem[8'h0c] = 32'h000000ff;
    bus(2'b10, 1'b0, 8'h10, 32'h0);
    check_eq("b2b_rd_10", hrdata, 32'hffffff00);
    bus(2'b11, 1'b0, 8'h0c, 32'h0);
    check_eq("b2b_rd_0c", hrdata, 32'h000000ff);
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("b2b_rd_idle", hrdata, 32'h0);
    $display("back-to-back reads 0x10, 0x0c");

    // Write then read of the same word: read returns old contents.
    dut.u_array.mem[8'h0c] = 32'h000000d0;
    bus(2'b10, 1'b1, 8'h0c, 32'h0);
    bus(2'b10, 1'b0, 8'h0c, 32'h12345678);
    check_eq("wr_rd_old", hrdata, 32'h000000d0);
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("wr_rd_mem", dut.u_array.mem[8'h0c], 32'h12345678);
    $display("write/read 0x0c: read %s", (fails == 0) ? "old data" : "unexpected");

    // Ten (IDLE, NONSEQ write) pairs.
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      bus(2'b00, 1'b0, 8'h00, (i == 0) ? 32'h0 : 32'hc0de0000 + 32'(i - 1));
      cycles++;
      check_eq("idle_wr_hready", 32'(hready), 32'h1);
      bus(2'b10, 1'b1, 8'h40 + 8'(i), 32'h0);
      cycles++;
      check_eq("idle_wr_hready", 32'(hready), 32'h1);
    end
    bus(2'b00, 1'b0, 8'h00, 32'hc0de0009);
    cycles++;
    check_eq("idle_wr_cycles", 32'(cycles), 32'd21);
    for (int i = 0; i < 10; i++) begin
      check_eq("idle_wr_mem", dut.u_array.mem[8'h40 + 8'(i)], 32'hc0de0000 + 32'(i));
    end
    $display("10 idle/write pairs in %0d cycles", cycles);

    // Reset during a write data phase discards the write.
    dut.u_array.mem[8'h20] = 32'habcd0123;
    bus(2'b10, 1'b1, 8'h20, 32'h0);
    hresetn = 1'b0;
    bus(2'b00, 1'b0, 8'h00, 32'hdeadbeef);
    check_eq("midrst_hrdata", hrdata, 32'h0);
    check_eq("midrst_hready", 32'(hready), 32'h0);
    hresetn = 1'b1;
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("midrst_hready_up", 32'(hready), 32'h1);
    check_eq("midrst_mem_20", dut.u_array.mem[8'h20], 32'habcd0123);

    // Reset right after a read forces hrdata to 0 and blocks a new read.
    dut.u_array.mem[8'h21] = 32'h77778888;
    bus(2'b10, 1'b0, 8'h21, 32'h0);
    check_eq("rdrst_valid", hrdata, 32'h77778888);
    hresetn = 1'b0;
    bus(2'b10, 1'b0, 8'h21, 32'h0);
    check_eq("rdrst_hrdata", hrdata, 32'h0);
    hresetn = 1'b1;
    bus(2'b00, 1'b0, 8'h00, 32'h0);
    check_eq("rdrst_hready_up", 32'(hready), 32'h1);
    $display("reset mid-transfer: write discarded, hrdata cleared");

    // Randomized traffic against an array model.
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      dut.u_array.mem[i] = model_mem[i];
    end
    prev_wr = 1'b0;
    prev_addr = 8'h00;
    for (int k = 0; k < 400; k++) begin
      t = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      // Reads sample memory before the previous write lands.
      exp_rd = (t[1] && !w) ? model_mem[a] : 32'h0;
      if (prev_wr) model_mem[prev_addr] = d;
      prev_wr = t[1] && w;
      prev_addr = a;
      bus(t, w, a, d);
      check_eq("rand_hrdata", hrdata, exp_rd);
      check_eq("rand_hready", 32'(hready), 32'h1);
    end
    d = $urandom;
    if (prev_wr) model_mem[prev_addr] = d;
    bus(2'b00, 1'b0, 8'h00, d);
    for (int i = 0; i < 256; i++) begin
      check_eq("rand_mem", dut.u_array.mem[i], model_mem[i]);
    end
    $display("random traffic: 400 cycles, memory compared");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
